// File: rtl/sum_uart_rx_if.sv
// ---------------------------------------------------------------------------
// sum_uart_rx_if -- consumer-side handshake of the sum UART receiver.
//   rx_data      [7:0] last correctly framed byte (receiver -> consumer)
//   rx_valid           byte pending, held until rx_ack
//   rx_frame_err       one-cycle pulse on a bad stop bit
//   rx_overrun         sticky, a byte landed while one was still pending
//   rx_busy            receiver is inside a frame (not IDLE)
//   rx_ack             one-cycle acknowledge (consumer -> receiver)
// master = receiver, slave = consumer.
// ---------------------------------------------------------------------------
interface sum_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
  logic       rx_ack;

  modport master (
    output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/sum_uart_rx.sv
// ---------------------------------------------------------------------------
// sum_uart_rx -- 8N1 UART receiver recovering the sum byte sent by the
// sum/latch UART transmitter.
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   uart_rxd   serial line, idle high, LSB first, asynchronous to clk
//   rx         sum_uart_rx_if.master: rx_data/rx_valid/rx_frame_err/
//              rx_overrun/rx_busy out, rx_ack in
// Parameter CLKS_PER_BIT (8..65535) is the number of clk cycles per bit.
// ---------------------------------------------------------------------------
module sum_uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          uart_rxd,
  sum_uart_rx_if.master rx
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t      state_reg;
  logic        sync1_reg;
  logic        rxs_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  shift_reg;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= uart_rxd;
      rxs_reg   <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 16'd0;
      idx_reg         <= 3'd0;
      shift_reg       <= 8'h00;
      rx.rx_data      <= 8'h00;
      rx.rx_valid     <= 1'b0;
      rx.rx_frame_err <= 1'b0;
      rx.rx_overrun   <= 1'b0;
      rx.rx_busy      <= 1'b0;
    end else begin
      rx.rx_frame_err <= 1'b0;

      // Acknowledge only matters while a byte is pending. A byte completing
      // in the same cycle overrides these assignments further down.
      if (rx.rx_ack && rx.rx_valid) begin
        rx.rx_valid   <= 1'b0;
        rx.rx_overrun <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!rxs_reg) begin
            state_reg  <= START;
            cnt_reg    <= 16'd0;
            rx.rx_busy <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject short glitches.
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= 16'd0;
            if (!rxs_reg) begin
              state_reg <= DATA;
              idx_reg   <= 3'd0;
            end else begin
              state_reg  <= IDLE;
              rx.rx_busy <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg            <= 16'd0;
            shift_reg[idx_reg] <= rxs_reg;
            if (idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        // Returning to IDLE on the stop sample leaves the rest of the stop
        // bit free to catch an immediately following start bit.
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= 16'd0;
            if (rxs_reg) begin
              rx.rx_data    <= shift_reg;
              rx.rx_valid   <= 1'b1;
              // Overrun only if the previous byte is still pending and is
              // not being acknowledged right now; an ack clears it.
              rx.rx_overrun <= (rx.rx_valid && !rx.rx_ack) ? 1'b1 :
                               (rx.rx_ack ? 1'b0 : rx.rx_overrun);
              state_reg     <= IDLE;
              rx.rx_busy    <= 1'b0;
            end else begin
              rx.rx_frame_err <= 1'b1;
              state_reg       <= WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        // A stuck-low line must not retrigger a frame (and another error).
        WAIT_IDLE: begin
          if (rxs_reg) begin
            state_reg  <= IDLE;
            rx.rx_busy <= 1'b0;
          end
        end

        default: begin
          state_reg  <= IDLE;
          rx.rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_sum_uart_rx -- self-checking bench for sum_uart_rx (CLKS_PER_BIT=16).
// Frames are driven bit by bit; every well-framed byte is pushed to a
// scoreboard with its start cycle and popped when the receiver presents it.
// ---------------------------------------------------------------------------
module tb_sum_uart_rx;
  localparam int CPB = 16;
  localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic reset_n;
  logic uart_rxd;

  sum_uart_rx_if rif ();

  sum_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_rxd (uart_rxd),
    .rx       (rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid_rise = 0;
  int n_ferr   = 0;
  int n_busy   = 0;
  int snap_rise;
  logic       valid_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp, input int tol = 0);
    logic bad;
    n_checks++;
    if (tol == 0) bad = (got !== exp);
    else bad = (int'(got) < int'(exp) - tol) || (int'(got) > int'(exp) + tol);
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (reset_n) begin
      if (rif.rx_frame_err) n_ferr++;
      if (rif.rx_busy) n_busy++;
      if (rif.rx_valid && (!valid_prev || rif.rx_data != data_prev)) begin
        if (!valid_prev) n_valid_rise++;
        check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("rx_data", 32'(rif.rx_data), 32'(mon_e.data));
          check_eq("latency", 32'(cyc - (mon_e.start + 1)), 32'(LAT), 1);
          $display("rx byte 0x%02h latency %0d cycles", rif.rx_data,
                   cyc - (mon_e.start + 1));
        end
      end
    end
    valid_prev = rif.rx_valid;
    data_prev  = rif.rx_data;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; leaves the line at the stop-bit level. With
  // ack_on_done, rx_ack is high on the byte-completion edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic ack_on_done);
    @(posedge clk);
    #1;
    uart_rxd = 1'b0;
    if (stop_bit) sb.push_back(exp_t'{data: d, start: cyc});
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      idle(CPB);
    end
    uart_rxd = stop_bit;
    for (int c = 0; c < CPB; c++) begin
      rif.rx_ack = ack_on_done && (c == CPB / 2 + 2);
      idle(1);
    end
    rif.rx_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    rif.rx_ack = 1'b1;
    idle(1);
    rif.rx_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"},  32'(rif.rx_data), 0);
    check_eq({tag, "_valid"}, 32'(rif.rx_valid), 0);
    check_eq({tag, "_ferr"},  32'(rif.rx_frame_err), 0);
    check_eq({tag, "_ovr"},   32'(rif.rx_overrun), 0);
    check_eq({tag, "_busy"},  32'(rif.rx_busy), 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    uart_rxd   = 1'b1;
    rif.rx_ack = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(10);

    // Single good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(5);
    check_eq("a5_valid", 32'(rif.rx_valid), 1);
    check_eq("a5_data", 32'(rif.rx_data), 32'hA5);
    check_eq("a5_no_ferr", 32'(n_ferr), 0);
    pulse_ack();
    check_eq("a5_ack_valid", 32'(rif.rx_valid), 0);
    pulse_ack();
    check_eq("idle_ack_valid", 32'(rif.rx_valid), 0);
    check_eq("idle_ack_data", 32'(rif.rx_data), 32'hA5);

    // Short low glitch
    n_busy = 0;
    snap_rise = n_valid_rise;
    uart_rxd = 1'b0;
    idle(4);
    uart_rxd = 1'b1;
    idle(30);
    check_eq("glitch_busy_seen", 32'(n_busy != 0), 1);
    check_eq("glitch_busy_now", 32'(rif.rx_busy), 0);
    check_eq("glitch_no_valid", 32'(n_valid_rise), 32'(snap_rise));
    check_eq("glitch_no_ferr", 32'(n_ferr), 0);

    // Bad stop bit, line held low afterwards
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    uart_rxd = 1'b1;
    idle(20);
    check_eq("ferr_count", 32'(n_ferr), 1);
    check_eq("ferr_valid", 32'(rif.rx_valid), 0);
    check_eq("ferr_data_kept", 32'(rif.rx_data), 32'hA5);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(5);
    check_eq("after_ferr_data", 32'(rif.rx_data), 32'h0F);
    pulse_ack();

    // Back-to-back without ack -> overrun
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    idle(5);
    check_eq("ovr_data", 32'(rif.rx_data), 32'h34);
    check_eq("ovr_valid", 32'(rif.rx_valid), 1);
    check_eq("ovr_flag", 32'(rif.rx_overrun), 1);
    pulse_ack();
    check_eq("ovr_ack_valid", 32'(rif.rx_valid), 0);
    check_eq("ovr_ack_flag", 32'(rif.rx_overrun), 0);

    // Ack on the completion cycle while a byte is pending
    send_frame(8'h11, 1'b1, 1'b0);
    check_eq("pend_ovr", 32'(rif.rx_overrun), 0);
    send_frame(8'h55, 1'b1, 1'b1);
    idle(2);
    check_eq("ackdone_valid", 32'(rif.rx_valid), 1);
    check_eq("ackdone_data", 32'(rif.rx_data), 32'h55);
    check_eq("ackdone_ovr", 32'(rif.rx_overrun), 0);

    // Reset in the middle of data bit 4 of 0xFF
    @(posedge clk);
    #1;
    uart_rxd = 1'b0;
    idle(CPB);
    uart_rxd = 1'b1;
    idle(4 * CPB + CPB / 2);
    check_eq("midframe_busy", 32'(rif.rx_busy), 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle(3);
    reset_n = 1'b1;
    snap_rise = n_valid_rise;
    idle(200);
    check_eq("postreset_no_valid", 32'(n_valid_rise), 32'(snap_rise));
    check_eq("postreset_busy", 32'(rif.rx_busy), 0);
    check_eq("postreset_ferr", 32'(n_ferr), 1);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(5);
    check_eq("postreset_data", 32'(rif.rx_data), 32'h7E);
    check_eq("postreset_valid", 32'(rif.rx_valid), 1);
    pulse_ack();

    idle(20);
    check_eq("sb_drained", 32'(sb.size()), 0);
    check_eq("total_ferr", 32'(n_ferr), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_uart_rx.md
SUM_UART_RX -- requirements
Module: sum_uart_rx

Downstream stage of the sum/latch UART transmitter: receives the 8N1 frame on the transmitter's serial line and recovers the sum byte.

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, giving clk cycles per UART bit (legal range 8..65535).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 uart_rxd  input  1  serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-005 rx_ack  input  1  one-cycle consumer acknowledge; clears rx_valid and rx_overrun.
REQ-006 rx_data  output  8  last correctly framed byte; stable while rx_valid=1.
REQ-007 rx_valid  output  1  level; high from byte completion until rx_ack.
REQ-008 rx_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 rx_overrun  output  1  sticky; a byte completed while rx_valid was already 1.
REQ-010 rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 uart_rxd SHALL pass through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized signal rxs only.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE; a bit-period counter (16 bit) and bit index (3 bit) SHALL be used.
REQ-013 IDLE: on rxs=0 go to START, clear counter.
REQ-014 START: after CLKS_PER_BIT/2 (integer division) cycles, sample rxs; 0 -> DATA with counter cleared, bit index 0; 1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA: every CLKS_PER_BIT cycles sample rxs into shift register bit [index], LSB first; after index 7 go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> load rx_data, set rx_valid, return to IDLE same edge; 0 -> pulse rx_frame_err, leave rx_data/rx_valid unchanged, go to WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until rxs=1, then IDLE (break/stuck-low line produces exactly one rx_frame_err).
REQ-018 Latency: rx_valid SHALL rise exactly 2 + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk edges after the first edge sampling uart_rxd low (±1 cycle tolerance allowed only for synchronizer phase).
REQ-019 Byte completion with rx_valid=1 and no rx_ack in that cycle: overwrite rx_data, keep rx_valid=1, set rx_overrun.
REQ-020 rx_ack in the same cycle as byte completion: new byte wins; rx_valid stays 1, rx_overrun cleared (not set).
REQ-021 rx_ack with rx_valid=0: no effect.
REQ-022 Back-to-back frames (start bit immediately after stop sample) SHALL be received without loss.

Reset
REQ-023 On reset_n=0, immediately: state=IDLE, rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, synchronizer=1, counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid or rx_frame_err; after release, reception restarts only on a new falling edge.

Verification (bench uses CLKS_PER_BIT=16)
REQ-025 Send 8'hA5 with valid stop -> rx_data=8'hA5, rx_valid=1 at 2+1+8+144 cycles after start edge, rx_frame_err never high.
REQ-026 Low pulse of 4 cycles on idle line -> rx_busy high briefly, returns IDLE, no rx_valid, no rx_frame_err.
REQ-027 Send 8'h3C with stop bit 0, line held low 40 cycles -> exactly one rx_frame_err pulse, rx_valid stays 0, rx_data unchanged, next frame 8'h0F received correctly.
REQ-028 Send 8'h12 then 8'h34 back-to-back without rx_ack -> rx_data=8'h34, rx_valid=1, rx_overrun=1; rx_ack -> both 0.
REQ-029 Assert reset_n=0 during DATA bit 4 of 8'hFF -> all outputs at reset values, no rx_valid after release until a full new frame 8'h7E yields rx_data=8'h7E.
REQ-030 rx_ack asserted on the byte-completion cycle of 8'h55 while prior byte pending -> rx_valid=1, rx_data=8'h55, rx_overrun=0.
